// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin burst arbiter sharing one single-port RAM among NREQ requesters.
// Rev 1.0 - initial release.
`default_nettype none
`timescale 1ns/1ps

module ram_port_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 16,
  parameter int DW   = 16,
  parameter int LW   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*LW-1:0] req_len,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    word_ack,
  output logic [DW-1:0]      rd_data,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic               mem_en,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata,
  input  logic               mem_ack
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   winner, last_winner, sel;
  logic            found;
  logic [NREQ-1:0] req_m, sel_oh, win_oh;
  logic [AW-1:0]   base;
  logic [LW-1:0]   len, count, count_inc, sel_len;
  logic            we;
  logic [DW-1:0]   wdata_q;

  // The requester whose done is pulsing may still hold req this cycle; skip it.
  assign req_m     = req & ~done;
  assign count_inc = count + 1'b1;
  assign sel_len   = req_len[sel*LW +: LW];
  assign sel_oh    = {{(NREQ-1){1'b0}}, 1'b1} << sel;
  assign win_oh    = {{(NREQ-1){1'b0}}, 1'b1} << winner;
  assign busy      = (state != IDLE);

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_m[(int'(last_winner) + 1 + k) % NREQ]) begin
        found = 1'b1;
        sel   = IW'((int'(last_winner) + 1 + k) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: if (found) state_nxt = (sel_len == '0) ? DONE : XFER;
      XFER: begin
        mem_en    = 1'b1;
        mem_we    = we;
        mem_addr  = base + AW'(count);
        mem_wdata = wdata_q;
        if (mem_ack) state_nxt = (count_inc < len) ? GAP : DONE;
      end
      GAP:     state_nxt = XFER;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      winner      <= '0;
      last_winner <= IW'(NREQ - 1);
      gnt         <= '0;
      done        <= '0;
      word_ack    <= '0;
      rd_data     <= '0;
      base        <= '0;
      len         <= '0;
      count       <= '0;
      we          <= 1'b0;
      wdata_q     <= '0;
    end else begin
      word_ack <= '0;
      done     <= '0;
      case (state)
        IDLE: if (found) begin
          winner  <= sel;
          gnt     <= sel_oh;
          base    <= req_addr[sel*AW +: AW];
          len     <= sel_len;
          we      <= req_we[sel];
          count   <= '0;
          wdata_q <= req_wdata[sel*DW +: DW];
        end
        XFER: if (mem_ack) begin
          count    <= count_inc;
          word_ack <= win_oh;
          rd_data  <= mem_rdata;
        end
        // Requester updated its write word during the word_ack cycle.
        GAP: wdata_q <= req_wdata[winner*DW +: DW];
        DONE: begin
          gnt         <= '0;
          done        <= win_oh;
          last_winner <= winner;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: scoreboard bench with RAM responder and requester models.
// Rev 1.0 - initial release.
`default_nettype none
`timescale 1ns/1ps

module tb_ram_port_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int LW   = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [NREQ-1:0]    req, req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*LW-1:0] req_len;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt, word_ack, done;
  logic [DW-1:0]      rd_data, mem_wdata, mem_rdata;
  logic [AW-1:0]      mem_addr;
  logic               busy, mem_en, mem_we, mem_ack;

  ram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .LW(LW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata), .gnt(gnt), .word_ack(word_ack),
    .rd_data(rd_data), .done(done), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    int          r;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } acc_t;

  acc_t        exp_q[$];
  acc_t        ack_q[$];
  int          gnt_log[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          acks_seen[NREQ];
  int          done_cnt[NREQ];
  int          bursts_left[NREQ];
  int          widx[NREQ];
  logic [15:0] cfg_d0[NREQ];
  int          ack_delay = 0;
  bit          spurious  = 1'b0;
  logic [15:0] ram [logic [15:0]];

  function automatic logic [15:0] ram_read(input logic [15:0] a);
    if (ram.exists(a)) return ram[a];
    return a ^ 16'h5A5A;
  endfunction

  // RAM responder: acks ack_delay cycles after mem_en rises; optional ack noise while idle.
  initial begin : responder
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_en && reset) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = ram_read(mem_addr);
          if (mem_we) ram[mem_addr] = mem_wdata;
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack   = spurious;
        mem_rdata = '0;
        wait_cnt  = 0;
      end
    end
  end

  // Requester model: next write word after each word_ack, drop req after last done.
  initial begin : requester_model
    forever begin
      @(posedge clk); #1;
      for (int r = 0; r < NREQ; r++) begin
        if (word_ack[r]) begin
          widx[r]++;
          req_wdata[r*DW +: DW] = cfg_d0[r] + 16'(widx[r]);
        end
        if (done[r] && bursts_left[r] > 0) begin
          bursts_left[r]--;
          widx[r] = 0;
          req_wdata[r*DW +: DW] = cfg_d0[r];
          if (bursts_left[r] == 0) req[r] = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    acc_t            a;
    logic [NREQ-1:0] oh, prev_gnt;
    bit              prev_acc;
    prev_gnt = '0;
    prev_acc = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        n_checks++;
        if ($countones(gnt) > 1 || (gnt != '0 && done != '0 && gnt != done)) begin
          n_fail++;
          $display("FAIL grant_exclusive: gnt=%b done=%b, required one-hot and disjoint", gnt, done);
        end
        if (prev_acc) begin
          n_checks++;
          if (mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL word_gap: mem_en=%b after completed word, required 0", mem_en);
          end
        end
        if (ack_q.size() > 0) begin
          a  = ack_q.pop_front();
          oh = '0;
          oh[a.r] = 1'b1;
          n_checks++;
          if (word_ack !== oh || (!a.we && rd_data !== a.rdata)) begin
            n_fail++;
            $display("FAIL word_ack: word_ack=%b rd_data=%h, required %b / %h", word_ack, rd_data, oh, a.we ? rd_data : a.rdata);
          end
        end else if (word_ack !== '0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_word_ack: word_ack=%b, required 000", word_ack);
        end
        for (int r = 0; r < NREQ; r++) begin
          if (word_ack[r]) acks_seen[r]++;
          if (done[r]) done_cnt[r]++;
          if (gnt[r] && prev_gnt == '0) gnt_log.push_back(r);
        end
        prev_acc = mem_en && mem_ack;
        if (prev_acc) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_access: addr=%h we=%b, required no access", mem_addr, mem_we);
          end else begin
            a  = exp_q.pop_front();
            oh = '0;
            oh[a.r] = 1'b1;
            if (mem_addr !== a.addr || mem_we !== a.we || gnt !== oh || (a.we && mem_wdata !== a.wdata)) begin
              n_fail++;
              $display("FAIL access: addr=%h we=%b wdata=%h gnt=%b, required %h %b %h %b",
                       mem_addr, mem_we, mem_wdata, gnt, a.addr, a.we, a.wdata, oh);
            end
            ack_q.push_back(a);
          end
        end
      end else begin
        prev_acc = 1'b0;
      end
      prev_gnt = gnt;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs;
    for (int r = 0; r < NREQ; r++) begin
      acks_seen[r] = 0;
      done_cnt[r]  = 0;
    end
    gnt_log.delete();
  endtask

  task automatic clear_stimulus;
    req = '0;
    for (int r = 0; r < NREQ; r++) begin
      bursts_left[r] = 0;
      widx[r]        = 0;
    end
    exp_q.delete();
    ack_q.delete();
  endtask

  task automatic apply_reset;
    @(negedge clk);
    reset = 1'b0;
    clear_stimulus();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic start_burst(input int r, input bit we, input logic [15:0] addr,
                             input int len, input logic [15:0] d0, input int n);
    cfg_d0[r]      = d0;
    widx[r]        = 0;
    bursts_left[r] = n;
    req_we[r]      = we;
    req_addr[r*AW +: AW]  = addr;
    req_len[r*LW +: LW]   = LW'(len);
    req_wdata[r*DW +: DW] = d0;
    req[r]         = 1'b1;
  endtask

  task automatic push_exp(input int r, input bit we, input logic [15:0] addr,
                          input int len, input logic [15:0] d0);
    acc_t a;
    for (int i = 0; i < len; i++) begin
      a.r     = r;
      a.we    = we;
      a.addr  = addr + 16'(i);
      a.wdata = d0 + 16'(i);
      a.rdata = ram_read(a.addr);
      exp_q.push_back(a);
    end
  endtask

  task automatic wait_bursts(input string name);
    bit ok = 1'b0;
    int busy_left;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      busy_left = 0;
      for (int r = 0; r < NREQ; r++) busy_left += bursts_left[r];
      if (busy_left == 0 && !busy && exp_q.size() == 0 && ack_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d accesses outstanding, required 0 within budget", name, exp_q.size());
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    clear_stimulus();
    req_we = '0; req_addr = '0; req_len = '0; req_wdata = '0;
    #3;
    n_checks++;
    if ({gnt, word_ack, done} !== '0) begin
      n_fail++; $display("FAIL reset_handshake: gnt/ack/done=%b, required 0", {gnt, word_ack, done});
    end
    n_checks++;
    if ({busy, mem_en, mem_we} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: busy/en/we=%b, required 000", {busy, mem_en, mem_we});
    end
    n_checks++;
    if (mem_addr !== 16'h0000) begin
      n_fail++; $display("FAIL reset_addr: mem_addr=%h, required 0000", mem_addr);
    end
    n_checks++;
    if ({mem_wdata, rd_data} !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: wdata/rdata=%h, required 0", {mem_wdata, rd_data});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || gnt !== '0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b gnt=%b, required 0 / 000", busy, gnt);
    end
  endtask

  task automatic test_read_single;
    acc_t a;
    clear_logs();
    ram[16'h0100] = 16'hBEEF;
    ack_delay = 2;
    a.r = 0; a.we = 1'b0; a.addr = 16'h0100; a.wdata = 16'h0000; a.rdata = 16'hBEEF;
    exp_q.push_back(a);
    @(posedge clk); #1;
    start_burst(0, 1'b0, 16'h0100, 1, 16'h0000, 1);
    @(negedge clk);
    n_checks++;
    if (gnt !== 3'b000) begin
      n_fail++; $display("FAIL read_grant_early: gnt=%b, required 000", gnt);
    end
    @(negedge clk);
    n_checks++;
    if (gnt !== 3'b001 || mem_en !== 1'b1) begin
      n_fail++; $display("FAIL read_grant_latency: gnt=%b mem_en=%b, required 001 / 1", gnt, mem_en);
    end
    wait_bursts("read_single");
    n_checks++;
    if (acks_seen[0] !== 1 || done_cnt[0] !== 1 || gnt !== 3'b000) begin
      n_fail++; $display("FAIL read_counts: acks=%0d done=%0d gnt=%b, required 1 / 1 / 000", acks_seen[0], done_cnt[0], gnt);
    end
  endtask

  task automatic test_write_wrap;
    clear_logs();
    ack_delay = 0;
    spurious  = 1'b1;
    push_exp(1, 1'b1, 16'hFFFE, 4, 16'h0001);
    @(posedge clk); #1;
    start_burst(1, 1'b1, 16'hFFFE, 4, 16'h0001, 1);
    wait_bursts("write_wrap");
    spurious = 1'b0;
    n_checks++;
    if (acks_seen[1] !== 4 || done_cnt[1] !== 1) begin
      n_fail++; $display("FAIL write_counts: acks=%0d done=%0d, required 4 / 1", acks_seen[1], done_cnt[1]);
    end
    n_checks++;
    if (ram_read(16'h0000) !== 16'h0003 || ram_read(16'h0001) !== 16'h0004) begin
      n_fail++; $display("FAIL write_wrap_data: ram[0]=%h ram[1]=%h, required 0003 / 0004", ram_read(16'h0000), ram_read(16'h0001));
    end
  endtask

  task automatic test_all_three;
    int want[3] = '{0, 1, 2};
    apply_reset();
    clear_logs();
    ack_delay = 1;
    push_exp(0, 1'b0, 16'h1000, 2, 16'h0000);
    push_exp(1, 1'b0, 16'h1100, 2, 16'h0000);
    push_exp(2, 1'b0, 16'h1200, 2, 16'h0000);
    @(posedge clk); #1;
    for (int r = 0; r < NREQ; r++) start_burst(r, 1'b0, 16'h1000 + 16'(r * 256), 2, 16'h0000, 1);
    wait_bursts("all_three");
    n_checks++;
    if (gnt_log.size() !== 3) begin
      n_fail++; $display("FAIL all_three_grants: %0d grants, required 3", gnt_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (gnt_log[i] !== want[i]) begin
          n_fail++; $display("FAIL all_three_order[%0d]: requester %0d, required %0d", i, gnt_log[i], want[i]);
        end
      end
    end
    n_checks++;
    if (done_cnt[0] !== 1 || done_cnt[1] !== 1 || done_cnt[2] !== 1) begin
      n_fail++; $display("FAIL all_three_done: %0d %0d %0d, required 1 1 1", done_cnt[0], done_cnt[1], done_cnt[2]);
    end
  endtask

  task automatic test_back_to_back;
    int want[5] = '{0, 2, 0, 2, 0};
    clear_logs();
    ack_delay = 0;
    for (int i = 0; i < 5; i++) begin
      if (want[i] == 0) push_exp(0, 1'b0, 16'h3000, 1, 16'h0000);
      else              push_exp(2, 1'b0, 16'h3100, 1, 16'h0000);
    end
    @(posedge clk); #1;
    start_burst(0, 1'b0, 16'h3000, 1, 16'h0000, 3);
    @(posedge clk); #1;
    start_burst(2, 1'b0, 16'h3100, 1, 16'h0000, 2);
    wait_bursts("back_to_back");
    n_checks++;
    if (gnt_log.size() !== 5) begin
      n_fail++; $display("FAIL alternate_grants: %0d grants, required 5", gnt_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (gnt_log[i] !== want[i]) begin
          n_fail++; $display("FAIL alternate_order[%0d]: requester %0d, required %0d", i, gnt_log[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_len_zero;
    clear_logs();
    @(posedge clk); #1;
    start_burst(0, 1'b0, 16'h4000, 0, 16'h0000, 1);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (gnt !== 3'b001 || done !== 3'b000 || mem_en !== 1'b0) begin
      n_fail++; $display("FAIL len0_grant: gnt=%b done=%b en=%b, required 001 000 0", gnt, done, mem_en);
    end
    @(negedge clk);
    n_checks++;
    if (gnt !== 3'b000 || done !== 3'b001) begin
      n_fail++; $display("FAIL len0_done: gnt=%b done=%b, required 000 001", gnt, done);
    end
    wait_bursts("len_zero");
    n_checks++;
    if (done_cnt[0] !== 1 || acks_seen[0] !== 0) begin
      n_fail++; $display("FAIL len0_counts: done=%0d acks=%0d, required 1 / 0", done_cnt[0], acks_seen[0]);
    end
  endtask

  task automatic test_reset_midburst;
    bit hit = 1'b0;
    clear_logs();
    ack_delay = 1;
    push_exp(0, 1'b0, 16'h2000, 8, 16'h0000);
    @(posedge clk); #1;
    start_burst(0, 1'b0, 16'h2000, 8, 16'h0000, 1);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (acks_seen[0] == 2 && mem_en) begin
        hit = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!hit) begin
      n_fail++; $display("FAIL midburst_reach: acks=%0d, required word 3 in flight", acks_seen[0]);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({gnt, word_ack, done, busy, mem_en, mem_we} !== '0 || mem_addr !== 16'h0000) begin
      n_fail++; $display("FAIL midburst_async: gnt=%b busy=%b en=%b addr=%h, required all 0", gnt, busy, mem_en, mem_addr);
    end
    clear_stimulus();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (done_cnt[0] !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midburst_no_done: done=%0d busy=%b, required 0 / 0", done_cnt[0], busy);
    end
    clear_logs();
    push_exp(0, 1'b0, 16'h5000, 1, 16'h0000);
    push_exp(1, 1'b0, 16'h5100, 1, 16'h0000);
    @(posedge clk); #1;
    start_burst(1, 1'b0, 16'h5100, 1, 16'h0000, 1);
    start_burst(0, 1'b0, 16'h5000, 1, 16'h0000, 1);
    wait_bursts("post_reset");
    n_checks++;
    if (gnt_log.size() !== 2 || gnt_log[0] !== 0) begin
      n_fail++; $display("FAIL post_reset_first: %0d grants first=%0d, required 2 grants first=0",
                         gnt_log.size(), gnt_log.size() > 0 ? gnt_log[0] : -1);
    end
  endtask

  initial begin : main
    test_reset();
    test_read_single();
    test_write_wrap();
    test_all_three();
    test_back_to_back();
    test_len_zero();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter and sequencer that shares the single-port accelerator RAM between up to NREQ burst requesters: the DMA read channel, the DMA write-back channel and the fully-connected unit. It grants one requester at a time, holds the grant for the whole burst, and drives the RAM enable/address/write strobes word by word. It returns read data and per-word acknowledgements to the granted requester and pulses a completion flag at burst end.

## Interface
- NREQ, 3, number of requesters (2..8)
- AW, 16, RAM address width
- DW, 16, data word width
- LW, 6, burst length field width (max burst 2^LW-1 words)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request, held high until its done pulse
- req_we  in  NREQ  1 = write burst, 0 = read burst
- req_addr  in  NREQ*AW  burst start address, requester i at bits [i*AW +: AW]
- req_len  in  NREQ*LW  burst length in words
- req_wdata  in  NREQ*DW  current write word of each requester
- gnt  out  NREQ  one-hot grant, held for the whole burst
- word_ack  out  NREQ  one-cycle pulse per completed word to the granted requester
- rd_data  out  DW  read word, valid in word_ack cycle of a read burst
- done  out  NREQ  one-cycle pulse at burst end
- busy  out  1  high whenever state is not IDLE
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write strobe
- mem_addr  out  AW  RAM word address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid with mem_ack
- mem_ack  in  1  RAM completion for the current access (RAM finish)

## Operation
- States: IDLE, XFER, GAP, DONE.
- IDLE: if any req, select winner = first set bit searching upward (mod NREQ) from last_winner+1; latch its addr, len, we; count=0; assert gnt[winner]; go XFER (or DONE if len=0).
- XFER: mem_en=1, mem_we=latched we, mem_addr=base+count (mod 2^AW), mem_wdata=req_wdata of winner sampled on XFER entry and held. On mem_ack: count++, capture mem_rdata; go GAP if count<len, else DONE.
- GAP: mem_en=0 for one cycle; next word's wdata is sampled on return to XFER; go XFER.
- DONE: done[winner]=1 for one cycle, gnt drops; last_winner=winner; go IDLE.
- word_ack[winner] and rd_data are registered: word_ack pulses in the cycle after mem_ack sampled high; the requester presents the next write word by the end of that cycle.
- Grant is non-preemptive; a requester dropping req mid-burst does not abort the burst.
- len=0: gnt asserted, no RAM access, done pulses the cycle after the grant cycle.
- Address arithmetic is AW-bit unsigned and wraps 0xFFFF→0x0000.

## Timing
- Reset (asynchronous, reset=0): state=IDLE, last_winner=NREQ-1 (requester 0 first), every output 0 immediately, including mid-burst; the aborted burst never gets done.
- req high at edge k: gnt and mem_en high after edge k+1.
- Per word: mem_en held until mem_ack sampled; minimum 2 cycles/word (XFER with immediate ack + GAP).
- mem_ack outside XFER is ignored.
- Between bursts: one DONE cycle + one IDLE cycle minimum before the next grant.
- Simultaneous req of all requesters with last_winner=NREQ-1: order 0,1,2.
- Only one gnt bit is ever high; gnt and done of different requesters never overlap.

## Test plan
- Read len=1, req0, addr 0x0100, RAM acks 2 cycles after mem_en with 0xBEEF → mem_addr=0x0100, mem_we=0, word_ack[0] once with rd_data=0xBEEF, done[0] one pulse, gnt[0] low after.
- Write len=4, req1, addr 0xFFFE, data 1,2,3,4, immediate ack → mem_addr sequence FFFE,FFFF,0000,0001 with mem_wdata 1..4, mem_en low one cycle between words, 4 word_ack[1] pulses.
- All three req high from reset, len=2 each → grants 0,1,2 in order, no overlapping gnt, three done pulses.
- req0 held continuously re-requesting, req2 raised → grants alternate 0,2,0,2; req2 never waits more than one burst.
- req0 len=0 → gnt[0] one cycle, done[0] next cycle, mem_en never asserted.
- reset pulled low during word 3 of an 8-word burst → all outputs 0 at once, no done; after release, simultaneous req1 and req0 → gnt[0] first.
